// File: rtl/bram_fifo_ctrl.sv
// Show-ahead FIFO controller for an external dual-port block RAM.
// The RAM's registered read port is the FIFO head: a read is issued whenever
// the head is empty or being consumed, and the RAM output holds while no read
// is issued, so OUT_DATA stays stable under backpressure. Enqueue and read
// decisions both use the registered RAM occupancy. As a result the write and
// read pointers can only be equal when no read or no write is possible, and
// the two ports never touch the same address in one cycle.
module bram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FLUSH,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic [DATA_WIDTH-1:0] RAM_DI,
    output logic [ADDR_WIDTH-1:0] RAM_WR_ADDR,
    output logic                  RAM_WE,
    output logic [ADDR_WIDTH-1:0] RAM_RD_ADDR,
    output logic                  RAM_RE,
    input  logic [DATA_WIDTH-1:0] RAM_DO
);

    // Number of words the RAM can hold.
    localparam logic [ADDR_WIDTH:0] C_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_cnt;   // words written to RAM but not yet read out
    logic                  r_head_v;    // RAM output register holds a valid head word

    logic w_in_ready;
    logic w_enq;
    logic w_rd;
    logic w_deq;

    // Space check looks only at registered occupancy; a dequeue in the same
    // cycle frees a slot that becomes visible one cycle later.
    assign w_in_ready = !RESET && (r_ram_cnt < C_DEPTH);
    assign w_enq      = IN_VALID && w_in_ready && !FLUSH;
    // Refill the head whenever it is empty or being consumed this cycle.
    assign w_rd       = (r_ram_cnt != '0) && (!r_head_v || OUT_READY) && !FLUSH;
    assign w_deq      = r_head_v && OUT_READY;

    assign IN_READY    = w_in_ready;
    assign OUT_VALID   = r_head_v;
    assign OUT_DATA    = RAM_DO;
    assign COUNT       = r_ram_cnt + {{ADDR_WIDTH{1'b0}}, r_head_v};

    assign RAM_WE      = w_enq;
    assign RAM_WR_ADDR = r_wr_ptr;
    assign RAM_DI      = IN_DATA;
    assign RAM_RE      = w_rd;
    assign RAM_RD_ADDR = r_rd_ptr;

    // Pointer advance on accepted writes and issued reads; flush rewinds both.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // RAM occupancy: simultaneous write and read cancel out.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ram_cnt <= '0;
        end else if (FLUSH) begin
            r_ram_cnt <= '0;
        end else begin
            case ({w_enq, w_rd})
                2'b10:   r_ram_cnt <= r_ram_cnt + (ADDR_WIDTH + 1)'(1);
                2'b01:   r_ram_cnt <= r_ram_cnt - (ADDR_WIDTH + 1)'(1);
                default: r_ram_cnt <= r_ram_cnt;
            endcase
        end
    end

    // Head valid: a read refills it next cycle, otherwise a dequeue empties it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_head_v <= 1'b0;
        end else if (FLUSH) begin
            r_head_v <= 1'b0;
        end else if (w_rd) begin
            r_head_v <= 1'b1;
        end else if (w_deq) begin
            r_head_v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl with a behavioural block RAM (registered read,
// output held when read enable is low). A queue scoreboard records accepted
// words and checks them on dequeue; a small occupancy model gives the expected
// handshake, RAM enable and COUNT values every cycle.
module tb_bram_fifo_ctrl;

    localparam int AW = 2;
    localparam int DW = 8;

    logic          CLK;
    logic          RESET;
    logic          FLUSH;
    logic [DW-1:0] IN_DATA;
    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [AW:0]   COUNT;
    logic [DW-1:0] RAM_DI;
    logic [AW-1:0] RAM_WR_ADDR;
    logic          RAM_WE;
    logic [AW-1:0] RAM_RD_ADDR;
    logic          RAM_RE;
    logic [DW-1:0] RAM_DO;

    bram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .FLUSH       (FLUSH),
        .IN_DATA     (IN_DATA),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .OUT_DATA    (OUT_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .COUNT       (COUNT),
        .RAM_DI      (RAM_DI),
        .RAM_WR_ADDR (RAM_WR_ADDR),
        .RAM_WE      (RAM_WE),
        .RAM_RD_ADDR (RAM_RD_ADDR),
        .RAM_RE      (RAM_RE),
        .RAM_DO      (RAM_DO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural dual-port RAM.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial RAM_DO = '0;
    always @(posedge CLK) begin
        if (RAM_WE) mem[RAM_WR_ADDR] <= RAM_DI;
        if (RAM_RE) RAM_DO <= mem[RAM_RD_ADDR];
    end

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] sb_q [$];
    int            m_ram_cnt = 0;
    bit            m_head_v  = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    logic          s_in_ready, s_re, s_we, s_ov;
    logic [DW-1:0] s_od;
    logic [AW:0]   s_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_ram_cnt  = 0;
        m_head_v   = 1'b0;
        prev_stall = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, then
    // advance the model to what the next rising edge should commit.
    task automatic do_cycle(input bit iv, input logic [DW-1:0] id, input bit ordy, input bit fl);
        bit            exp_rdy, enq, rd, deq;
        logic [DW-1:0] exp_d;
        @(negedge CLK);
        IN_VALID  = iv;
        IN_DATA   = id;
        OUT_READY = ordy;
        FLUSH     = fl;
        #1;
        s_in_ready = IN_READY;
        s_re       = RAM_RE;
        s_we       = RAM_WE;
        s_ov       = OUT_VALID;
        s_od       = OUT_DATA;
        s_cnt      = COUNT;

        exp_rdy = (m_ram_cnt < (1 << AW));
        enq     = iv && exp_rdy && !fl;
        rd      = (m_ram_cnt != 0) && (!m_head_v || ordy) && !fl;
        deq     = m_head_v && ordy && !fl;

        chk("in_ready",  32'(IN_READY),  32'(exp_rdy));
        chk("out_valid", 32'(OUT_VALID), 32'(m_head_v));
        chk("count",     32'(COUNT),     32'(m_ram_cnt + int'(m_head_v)));
        chk("ram_we",    32'(RAM_WE),    32'(enq));
        chk("ram_re",    32'(RAM_RE),    32'(rd));
        chk("collision", 32'(RAM_WE && RAM_RE && (RAM_WR_ADDR == RAM_RD_ADDR)), 32'(0));
        if (enq) chk("ram_di", 32'(RAM_DI), 32'(id));
        if (prev_stall) begin
            chk("hold_valid", 32'(OUT_VALID), 32'(1));
            chk("hold_data",  32'(OUT_DATA),  32'(prev_data));
        end
        prev_stall = m_head_v && !ordy && !fl;
        prev_data  = OUT_DATA;

        if (fl) begin
            model_clear();
        end else begin
            if (deq && sb_q.size() > 0) begin
                exp_d = sb_q.pop_front();
                chk("out_data", 32'(OUT_DATA), 32'(exp_d));
                $display("%0t deq data=0x%02h count=%0d", $time, OUT_DATA, COUNT);
            end
            if (enq) sb_q.push_back(id);
            m_ram_cnt = m_ram_cnt + int'(enq) - int'(rd);
            m_head_v  = rd ? 1'b1 : (deq ? 1'b0 : m_head_v);
        end
    endtask

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;

        // Reset state
        @(negedge CLK); #1;
        chk("rst_in_ready",  32'(IN_READY),  32'(0));
        chk("rst_count",     32'(COUNT),     32'(0));
        chk("rst_out_valid", 32'(OUT_VALID), 32'(0));
        @(negedge CLK);
        RESET = 1'b0;
        model_clear();

        // Fill with consumer stalled: five words fit, the sixth is refused
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        do_cycle(1'b1, 8'h15, 1'b0, 1'b0);
        chk("fill_ready", 32'(s_in_ready), 32'(0));
        chk("fill_count", 32'(s_cnt), 32'(5));
        for (int i = 0; i < 6; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_empty", 32'(s_ov), 32'(0));

        // Latency through an empty FIFO
        do_cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lat_re", 32'(s_re), 32'(1));
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lat_valid", 32'(s_ov), 32'(1));
        chk("lat_data",  32'(s_od), 32'(8'hA5));
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lat_count", 32'(s_cnt), 32'(0));

        // Full-rate streaming
        for (int i = 0; i < 100; i++) begin
            do_cycle(1'b1, 8'(i), 1'b1, 1'b0);
            if (i >= 2) begin
                chk("stream_valid", 32'(s_ov),  32'(1));
                chk("stream_count", 32'(s_cnt), 32'(2));
            end
        end
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic with heavy backpressure
        for (int i = 0; i < 10000; i++)
            do_cycle($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 30, 1'b0);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rand_drained", 32'(s_cnt), 32'(0));

        // Full FIFO with a concurrent read: enqueue waits one cycle
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        do_cycle(1'b1, 8'h30, 1'b1, 1'b0);
        chk("full_ready0", 32'(s_in_ready), 32'(0));
        chk("full_count",  32'(s_cnt),      32'(5));
        do_cycle(1'b1, 8'h30, 1'b1, 1'b0);
        chk("full_ready1", 32'(s_in_ready), 32'(1));
        chk("full_we",     32'(s_we),       32'(1));
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush during a dequeue cycle
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_flush_count", 32'(s_cnt), 32'(3));
        do_cycle(1'b1, 8'h55, 1'b1, 1'b1);
        chk("flush_we", 32'(s_we), 32'(0));
        chk("flush_re", 32'(s_re), 32'(0));
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_flush_count", 32'(s_cnt), 32'(0));
        chk("post_flush_valid", 32'(s_ov),  32'(0));
        do_cycle(1'b1, 8'h77, 1'b1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_first_valid", 32'(s_ov), 32'(1));
        chk("flush_first_data",  32'(s_od), 32'(8'h77));
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
        @(posedge CLK); #2;
        RESET = 1'b1;
        #1;
        chk("areset_count", 32'(COUNT),     32'(0));
        chk("areset_valid", 32'(OUT_VALID), 32'(0));
        chk("areset_ready", 32'(IN_READY),  32'(0));
        chk("areset_we",    32'(RAM_WE),    32'(0));
        model_clear();
        IN_VALID = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        do_cycle(1'b1, 8'h77, 1'b1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rst_first_valid", 32'(s_ov), 32'(1));
        chk("rst_first_data",  32'(s_od), 32'(8'h77));
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rst_final_count", 32'(s_cnt), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
